cdc_write_arbiter: RTL

CDC_WRITE_ARBITER -- requirements
Module: cdc_write_arbiter

---
 rtl/cdc_pkg.sv | 7 +
 rtl/round_robin_pick.sv | 23 ++
 rtl/cdc_write_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and constants for the CDC buffer write path
package cdc_pkg;
  localparam int DATA_W = 16;
  localparam int GAP_W = 4;
  typedef logic [DATA_W-1:0] data_t;
  typedef enum logic {IDLE, GAP} state_t;
endpackage

// File: rtl/round_robin_pick.sv
// round_robin_pick: combinational round-robin winner, first valid at or after ptr
module round_robin_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDXW = $clog2(NUM_REQ)
) (
  input  logic [IDXW-1:0]    ptr,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    // Scan farthest-from-pointer first so the nearest valid requester overwrites last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        idx = IDXW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/cdc_write_arbiter.sv
// cdc_write_arbiter: round-robin arbiter feeding one CDC buffer write port with enforced idle gap
module cdc_write_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MIN_GAP = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         write_en,
  output logic [DATA_W-1:0]            write_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);
  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(MIN_GAP);
  state_t state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDXW-1:0] ptr_q, ptr_d, pick_idx, grant_id_q;
  logic [NUM_REQ-1:0] pick_grant;
  logic write_en_q, xfer;
  data_t write_data_q, sel_data;
  round_robin_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .ptr   (ptr_q),
    .valid (req_valid),
    .grant (pick_grant),
    .idx   (pick_idx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q <= '0;
      ptr_q <= '0;
      write_en_q <= 1'b0;
      write_data_q <= '0;
      grant_id_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      ptr_q <= ptr_d;
      write_en_q <= xfer;
      write_data_q <= xfer ? sel_data : write_data_q;
      grant_id_q <= xfer ? pick_idx : grant_id_q;
    end
  end
  always_comb begin
    xfer = |(req_valid & req_ready);
    sel_data = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    state_d = (xfer && GAP_LD != '0) ? GAP : (state_q == GAP && gap_q <= GAP_W'(1)) ? IDLE : state_q;
    gap_d = xfer ? GAP_LD : (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
    ptr_d = xfer ? ((pick_idx == IDXW'(NUM_REQ - 1)) ? '0 : pick_idx + IDXW'(1)) : ptr_q;
  end
  always_comb begin
    req_ready = (state_q == IDLE && !reset) ? pick_grant : '0;
    busy = write_en_q || state_q == GAP;
    write_en = write_en_q;
    write_data = write_data_q;
    grant_id = grant_id_q;
  end
endmodule
